// File: rtl/collision_detector.sv
// Per-frame pair-overlap collision detector with hit pulses and a per-frame summary.
// Latency: hitPulse 1 cycle after the threshold pixel; frameValid 1 cycle after startOfFrame.
// Backpressure: none; pixel-rate stream, all inputs consumed every cycle.
module collision_detector #(
  parameter int MIN_OVERLAP = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       drawReqTank,
  input  logic       drawReqBullet,
  input  logic       drawReqBrick,
  input  logic       drawReqBorder,
  output logic [3:0] hitPulse,
  output logic       frameValid,
  output logic [3:0] frameMask,
  output logic [7:0] collisionFrames
);

  localparam logic IDLE = 1'b0;
  localparam logic HIT  = 1'b1;
  localparam logic [5:0] MIN_CNT = 6'(MIN_OVERLAP);

  logic [5:0] ovCnt [4];
  logic [3:0] hitLatched;
  logic [3:0] overlap;
  logic [3:0] setHit;

  // Pair order: tank-brick, tank-border, bullet-brick, bullet-border.
  assign overlap = {drawReqBullet & drawReqBorder,
                    drawReqBullet & drawReqBrick,
                    drawReqTank   & drawReqBorder,
                    drawReqTank   & drawReqBrick};

  always_comb begin
    setHit = '0;
    for (int i = 0; i < 4; i++) begin
      setHit[i] = overlap[i] && (hitLatched[i] == IDLE) && (ovCnt[i] == MIN_CNT - 6'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      hitPulse        <= '0;
      frameValid      <= 1'b0;
      frameMask       <= '0;
      collisionFrames <= '0;
      hitLatched      <= {4{IDLE}};
      for (int i = 0; i < 4; i++) ovCnt[i] <= '0;
    end else if (startOfFrame) begin
      // Boundary cycle: overlaps are ignored, the ended frame is summarised.
      hitPulse   <= '0;
      frameValid <= 1'b1;
      frameMask  <= hitLatched;
      if (hitLatched != '0 && collisionFrames != 8'hFF)
        collisionFrames <= collisionFrames + 8'd1;
      hitLatched <= {4{IDLE}};
      for (int i = 0; i < 4; i++) ovCnt[i] <= '0;
    end else begin
      frameValid <= 1'b0;
      hitPulse   <= setHit;
      for (int i = 0; i < 4; i++) begin
        if (overlap[i] && ovCnt[i] < MIN_CNT)
          ovCnt[i] <= ovCnt[i] + 6'd1;
        if (setHit[i])
          hitLatched[i] <= HIT;
      end
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Directed self-checking bench for collision_detector with MIN_OVERLAP=4.
module tb_collision_detector;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       drawReqTank, drawReqBullet, drawReqBrick, drawReqBorder;
  logic [3:0] hitPulse;
  logic       frameValid;
  logic [3:0] frameMask;
  logic [7:0] collisionFrames;

  int checks = 0;
  int failures = 0;

  collision_detector #(.MIN_OVERLAP(4)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .drawReqTank(drawReqTank), .drawReqBullet(drawReqBullet),
    .drawReqBrick(drawReqBrick), .drawReqBorder(drawReqBorder),
    .hitPulse(hitPulse), .frameValid(frameValid),
    .frameMask(frameMask), .collisionFrames(collisionFrames)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs {tank,bullet,brick,border}; return #1 after the sampling edge.
  task automatic step(input logic rst, input logic sof, input logic [3:0] req);
    resetN        = rst;
    startOfFrame  = sof;
    drawReqTank   = req[3];
    drawReqBullet = req[2];
    drawReqBrick  = req[1];
    drawReqBorder = req[0];
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_TB   = 4'b1010; // tank+brick
  localparam logic [3:0] R_TD   = 4'b1001; // tank+border
  localparam logic [3:0] R_BBD  = 4'b0111; // bullet+brick+border
  localparam logic [3:0] R_BB   = 4'b0110; // bullet+brick

  task automatic test_reset();
    step(1'b1, 1'b0, R_NONE);
    step(1'b1, 1'b0, R_NONE);
    checks++; if (hitPulse !== 4'b0) begin failures++; $display("FAIL reset_hitPulse got=%b exp=0000", hitPulse); end
    checks++; if (frameValid !== 1'b0) begin failures++; $display("FAIL reset_frameValid got=%b exp=0", frameValid); end
    checks++; if (frameMask !== 4'b0) begin failures++; $display("FAIL reset_frameMask got=%b exp=0000", frameMask); end
    checks++; if (collisionFrames !== 8'd0) begin failures++; $display("FAIL reset_collisionFrames got=%0d exp=0", collisionFrames); end
    step(1'b0, 1'b0, R_NONE);
    checks++; if (hitPulse !== 4'b0 || frameValid !== 1'b0) begin failures++; $display("FAIL idle_outputs got=%b/%b exp=0000/0", hitPulse, frameValid); end
    step(1'b0, 1'b1, R_NONE);
    checks++; if (frameValid !== 1'b1) begin failures++; $display("FAIL idle_frameValid got=%b exp=1", frameValid); end
    checks++; if (frameMask !== 4'b0000) begin failures++; $display("FAIL idle_frameMask got=%b exp=0000", frameMask); end
    checks++; if (collisionFrames !== 8'd0) begin failures++; $display("FAIL idle_collisionFrames got=%0d exp=0", collisionFrames); end
    step(1'b0, 1'b0, R_NONE);
    checks++; if (frameValid !== 1'b0) begin failures++; $display("FAIL frameValid_one_cycle got=%b exp=0", frameValid); end
  endtask

  task automatic test_threshold();
    int pulses;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, R_TB);
      checks++; if (hitPulse !== 4'b0) begin failures++; $display("FAIL below_threshold k=%0d got=%b exp=0000", k, hitPulse); end
    end
    step(1'b0, 1'b0, R_NONE);
    step(1'b0, 1'b0, R_TB);
    checks++; if (hitPulse !== 4'b0001) begin failures++; $display("FAIL threshold_pulse got=%b exp=0001", hitPulse); end
    step(1'b0, 1'b0, R_NONE);
    checks++; if (hitPulse !== 4'b0000) begin failures++; $display("FAIL pulse_width got=%b exp=0000", hitPulse); end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, R_TB);
      if (hitPulse !== 4'b0) pulses++;
    end
    step(1'b0, 1'b0, R_NONE);
    if (hitPulse !== 4'b0) pulses++;
    checks++; if (pulses !== 0) begin failures++; $display("FAIL no_repulse got=%0d exp=0", pulses); end
    step(1'b0, 1'b1, R_NONE);
    checks++; if (frameValid !== 1'b1 || frameMask !== 4'b0001) begin failures++; $display("FAIL threshold_summary got=%b/%b exp=1/0001", frameValid, frameMask); end
    checks++; if (collisionFrames !== 8'd1) begin failures++; $display("FAIL threshold_count got=%0d exp=1", collisionFrames); end
  endtask

  task automatic test_frame_summary();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, R_BBD);
    step(1'b0, 1'b0, R_BBD);
    checks++; if (hitPulse !== 4'b1100) begin failures++; $display("FAIL dual_pulse got=%b exp=1100", hitPulse); end
    step(1'b0, 1'b0, R_BB);
    checks++; if (hitPulse !== 4'b0000) begin failures++; $display("FAIL dual_pulse_end got=%b exp=0000", hitPulse); end
    step(1'b0, 1'b1, R_NONE);
    checks++; if (frameValid !== 1'b1 || frameMask !== 4'b1100) begin failures++; $display("FAIL summary_mask got=%b/%b exp=1/1100", frameValid, frameMask); end
    checks++; if (collisionFrames !== 8'd2) begin failures++; $display("FAIL summary_count got=%0d exp=2", collisionFrames); end
    step(1'b0, 1'b0, R_NONE);
    checks++; if (frameMask !== 4'b1100) begin failures++; $display("FAIL mask_held got=%b exp=1100", frameMask); end
    step(1'b0, 1'b0, R_NONE);
    step(1'b0, 1'b1, R_NONE);
    checks++; if (frameValid !== 1'b1 || frameMask !== 4'b0000) begin failures++; $display("FAIL quiet_frame got=%b/%b exp=1/0000", frameValid, frameMask); end
    checks++; if (collisionFrames !== 8'd2) begin failures++; $display("FAIL quiet_count got=%0d exp=2", collisionFrames); end
  endtask

  task automatic test_boundary_overlap();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, R_TB);
    step(1'b0, 1'b1, R_TB);
    checks++; if (hitPulse !== 4'b0000) begin failures++; $display("FAIL boundary_pulse got=%b exp=0000", hitPulse); end
    checks++; if (frameMask !== 4'b0000 || collisionFrames !== 8'd2) begin failures++; $display("FAIL boundary_summary got=%b/%0d exp=0000/2", frameMask, collisionFrames); end
    // Counts must restart from zero after the boundary.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, R_TB);
      checks++; if (hitPulse !== 4'b0) begin failures++; $display("FAIL boundary_cleared k=%0d got=%b exp=0000", k, hitPulse); end
    end
    step(1'b0, 1'b1, R_NONE);
    checks++; if (frameMask !== 4'b0000) begin failures++; $display("FAIL boundary_next_mask got=%b exp=0000", frameMask); end
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, R_TD);
    step(1'b1, 1'b0, R_TD);
    checks++; if (collisionFrames !== 8'd0 || frameValid !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=%0d/%b exp=0/0", collisionFrames, frameValid); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, R_TD);
      checks++; if (hitPulse !== 4'b0) begin failures++; $display("FAIL midreset_pulse k=%0d got=%b exp=0000", k, hitPulse); end
    end
    step(1'b0, 1'b1, R_NONE);
    checks++; if (frameValid !== 1'b1 || frameMask !== 4'b0000) begin failures++; $display("FAIL midreset_summary got=%b/%b exp=1/0000", frameValid, frameMask); end
    step(1'b1, 1'b1, R_NONE);
    checks++; if (frameValid !== 1'b0) begin failures++; $display("FAIL reset_beats_sof got=%b exp=0", frameValid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, R_TD);
    checks++; if (hitPulse !== 4'b0010) begin failures++; $display("FAIL border_pulse got=%b exp=0010", hitPulse); end
    step(1'b0, 1'b1, R_NONE);
    checks++; if (frameValid !== 1'b1 || frameMask !== 4'b0010) begin failures++; $display("FAIL b2b_first got=%b/%b exp=1/0010", frameValid, frameMask); end
    step(1'b0, 1'b1, R_NONE);
    checks++; if (frameValid !== 1'b1 || frameMask !== 4'b0000) begin failures++; $display("FAIL b2b_second got=%b/%b exp=1/0000", frameValid, frameMask); end
    checks++; if (collisionFrames !== 8'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", collisionFrames); end
  endtask

  task automatic test_saturation();
    int exp_cf;
    exp_cf = 1;
    for (int f = 0; f < 260; f++) begin
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, R_TB);
      checks++; if (hitPulse !== 4'b0001) begin failures++; $display("FAIL sat_pulse f=%0d got=%b exp=0001", f, hitPulse); end
      step(1'b0, 1'b1, R_NONE);
      exp_cf = (exp_cf < 255) ? exp_cf + 1 : 255;
      checks++; if (frameValid !== 1'b1 || frameMask !== 4'b0001) begin failures++; $display("FAIL sat_summary f=%0d got=%b/%b exp=1/0001", f, frameValid, frameMask); end
      checks++; if (collisionFrames !== 8'(exp_cf)) begin failures++; $display("FAIL sat_count f=%0d got=%0d exp=%0d", f, collisionFrames, exp_cf); end
    end
    checks++; if (collisionFrames !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", collisionFrames); end
  endtask

  initial begin
    resetN = 1'b1; startOfFrame = 1'b0;
    drawReqTank = 1'b0; drawReqBullet = 1'b0; drawReqBrick = 1'b0; drawReqBorder = 1'b0;
    test_reset();
    test_threshold();
    test_frame_summary();
    test_boundary_overlap();
    test_reset_mid_frame();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
# collision_detector

Per-frame collision detector that sits directly downstream of the object bitmap stages. It consumes the registered `drawingRequest` outputs of the tank, bullet, brick and border bitmaps. It counts pixels where object pairs overlap and raises an immediate hit pulse once a pair reaches a minimum overlap. At each frame boundary it reports a latched per-frame collision summary to the game-control logic.

## Interface
Parameters:
- `MIN_OVERLAP`, 4: overlapping pixels per pair per frame needed to flag a collision; legal range 1..63.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system pixel clock.
- `resetN`  in  1  synchronous, active-high reset. The name follows codebase convention; polarity is high.
- `startOfFrame`  in  1  one-cycle pulse at the frame boundary, in blanking.
- `drawReqTank`  in  1  tank bitmap `drawingRequest`.
- `drawReqBullet`  in  1  bullet bitmap `drawingRequest`.
- `drawReqBrick`  in  1  brick bitmap `drawingRequest`.
- `drawReqBorder`  in  1  border bitmap `drawingRequest`.
- `hitPulse`  out  4  per-pair one-cycle pulse, at most once per pair per frame.
  - bit0 tank–brick, bit1 tank–border, bit2 bullet–brick, bit3 bullet–border.
- `frameValid`  out  1  one-cycle pulse carrying the summary of the frame just ended.
- `frameMask`  out  4  pairs that collided in the ended frame; held until the next `frameValid`.
- `collisionFrames`  out  8  count of frames with a nonzero `frameMask`; saturates at 255.

## Operation
- All four `drawReq*` inputs are already cycle-aligned, since every bitmap stage has one register stage. No further alignment is done here.
- Overlap for pair i in a cycle is the AND of its two requests, evaluated only when `startOfFrame`=0.
- Overlap counters:
  - Each pair has a 6-bit counter `ovCnt[i]`, cleared at reset and on `startOfFrame`.
  - The counter increments on overlap while below `MIN_OVERLAP`, then holds.
- Hit latch:
  - `hitLatched[i]` sets in the cycle `ovCnt[i]` goes from `MIN_OVERLAP`-1 to `MIN_OVERLAP`.
  - It clears on `startOfFrame`.
- `hitPulse[i]` is registered and equals 1 exactly in the cycle after `hitLatched[i]` sets. No second pulse occurs in the same frame, however many further overlapping pixels arrive.
- Frame boundary, in the cycle `startOfFrame`=1:
  - `frameMask` <= `hitLatched`, and `frameValid` <= 1 the next cycle.
  - If `hitLatched` != 0, `collisionFrames` <= min(`collisionFrames`+1, 255).
  - All `ovCnt` and `hitLatched` clear.
  - Any overlap in this cycle is ignored.
- There is no FSM beyond the per-pair two-state machine, IDLE (counting) → HIT (latched) → IDLE on `startOfFrame` or reset.
- Consecutive `startOfFrame` cycles are legal. Each one produces `frameValid`; the second reports mask 0.

## Timing
- Reset values, forced on the first edge with `resetN`=1:
  - `hitPulse`=0, `frameValid`=0, `frameMask`=0, `collisionFrames`=0.
  - All `ovCnt`=0 and all `hitLatched`=0.
- Hit latency is 1 cycle from the edge that samples the `MIN_OVERLAP`-th overlapping pixel to `hitPulse` high.
- Summary latency is 1 cycle from the `startOfFrame` sample to `frameValid` high, with `frameMask` valid in that same cycle.
- Reset mid-frame discards all partial counts. No `frameValid` or `hitPulse` is produced for the interrupted frame.
- If reset and `startOfFrame` are both high, reset wins: outputs go to reset values and `frameValid` stays 0.
- With `MIN_OVERLAP`=1, the first overlapping pixel produces `hitPulse` on the next cycle.
- Multiple pairs may latch on the same cycle. Their `hitPulse` bits then assert together.

## Test plan
- Reset then idle: hold `resetN`=1 for 2 cycles, then release with all requests 0 → every output 0. A later `startOfFrame` gives `frameValid`=1 and `frameMask`=0000, with `collisionFrames` staying 0.
- Threshold, `MIN_OVERLAP`=4: assert tank+brick together for 3 cycles → no pulse. A 4th overlapping cycle (non-contiguous is allowed) → `hitPulse`=0001 for exactly 1 cycle after. Ten further overlaps → no further pulse.
- Frame summary: bullet+brick 5 overlaps and bullet+border 4 overlaps, then `startOfFrame` → `frameValid`=1 next cycle, `frameMask`=1100, `collisionFrames`=1. The next frame has no overlap → `frameMask`=0000 and `collisionFrames` stays 1.
- Simultaneous hit on a boundary: tank+brick overlap on the cycle `startOfFrame`=1 after 3 prior overlaps → that overlap is ignored. `frameMask`=0000 and no `hitPulse`.
- Reset mid-frame: 3 tank–border overlaps, reset for 1 cycle, then 3 more overlaps → no `hitPulse`. The next `startOfFrame` reports `frameMask`=0000.
- Saturation: run 260 frames each containing a tank–brick hit → `collisionFrames`=255 and stays 255. The `frameMask`=0001 report keeps pulsing every frame.
